// File: rtl/db15_joy_tx.sv
// DB15 joystick link, device side: emulates the adapter's 74HC165 chain, latching
// {joy2, joy1} on the reader's load strobe and shifting one bit per reader clock.
module db15_joy_tx #(
  parameter int N_BITS = 12,
  parameter int FILT   = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [N_BITS-1:0] joy1,
  input  logic [N_BITS-1:0] joy2,
  input  logic              JOY_CLK,
  input  logic              JOY_LOAD,
  output logic              JOY_DATA,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              short_frame
);

  localparam int FW = 2 * N_BITS;
  localparam int IW = $clog2(FW);
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state;
  logic [FW-1:0] sr;
  logic [IW-1:0] idx;

  // Channel 0 carries JOY_CLK, channel 1 carries JOY_LOAD; idle level of both is high.
  logic [1:0] sync1, sync2, filt, filt_d;
  logic       clk_rise, load_fall, load_low;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {JOY_LOAD, JOY_CLK};
      sync2 <= sync1;
    end
  end

  generate
    if (FILT == 0) begin : g_nofilt
      assign filt = sync2;
    end else begin : g_filt
      for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl;

        // Level follows the synchronised input only after FILT consecutive disagreeing samples.
        always_ff @(posedge clk_sys) begin
          if (reset) begin
            cnt <= '0;
            lvl <= 1'b1;
          end else if (sync2[g] == lvl) begin
            cnt <= '0;
          end else if (cnt == CW'(FILT - 1)) begin
            cnt <= '0;
            lvl <= sync2[g];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        assign filt[g] = lvl;
      end
    end
  endgenerate

  assign clk_rise  = filt[0] & ~filt_d[0];
  assign load_fall = ~filt[1] & filt_d[1];
  assign load_low  = ~filt[1];

  // Load always takes priority over a shift edge arriving in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      idx         <= '0;
      filt_d      <= 2'b11;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'd0;
      short_frame <= 1'b0;
    end else begin
      filt_d     <= filt;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_low) begin
            state <= LOAD;
            sr    <= {joy2, joy1};
            idx   <= '0;
          end
        end
        LOAD: begin
          if (load_low) begin
            sr  <= {joy2, joy1};
            idx <= '0;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (load_fall) begin
            short_frame <= 1'b1;
            state       <= LOAD;
            sr          <= {joy2, joy1};
            idx         <= '0;
          end else if (clk_rise) begin
            sr  <= {1'b0, sr[FW-1:1]};
            idx <= idx + 1'b1;
            if (idx == IW'(FW - 2)) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (load_fall) begin
            state <= LOAD;
            sr    <= {joy2, joy1};
            idx   <= '0;
          end else if (clk_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial-in of the emulated chain is tied high, so an idle line reads as 1.
  assign JOY_DATA = (state == IDLE) ? 1'b1 : ~sr[0];

endmodule

// File: tb/tb_db15_joy_tx.sv
// Directed bench for db15_joy_tx: emulates the DB15 reader driving JOY_LOAD/JOY_CLK
// and checks serial bit order, frame bookkeeping, glitch filtering and priorities.
module tb_db15_joy_tx;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [11:0] joy1, joy2;
  logic        JOY_CLK, JOY_LOAD;
  logic        JOY_DATA, frame_done, short_frame;
  logic [7:0]  frame_cnt;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          done_before;
  logic [7:0]  exp_cnt;

  db15_joy_tx #(.N_BITS(12), .FILT(2)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joy1        (joy1),
    .joy2        (joy2),
    .JOY_CLK     (JOY_CLK),
    .JOY_LOAD    (JOY_LOAD),
    .JOY_DATA    (JOY_DATA),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .short_frame (short_frame)
  );

  always #5 clk_sys = ~clk_sys;

  // Counts every cycle frame_done is high, so a stuck pulse shows up as extra counts.
  always @(posedge clk_sys) if (frame_done === 1'b1) done_cnt++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] j1, input logic [11:0] j2);
    joy1 = j1;
    joy2 = j2;
  endtask

  task automatic shift_pulse(input int half);
    JOY_CLK = 1'b1;
    cycles(half);
    JOY_CLK = 1'b0;
    cycles(half);
  endtask

  task automatic load_pulse(input int w);
    JOY_LOAD = 1'b0;
    cycles(w);
    JOY_LOAD = 1'b1;
    cycles(w);
  endtask

  // Expects a freshly loaded frame; shifts all bits plus the trailing edge back to idle.
  task automatic shift_frame(input logic [23:0] exp, input int half, input int change_at,
                             input logic [11:0] new_j1);
    checkOutput("bit0", 32'(JOY_DATA), exp[0] ? 32'd0 : 32'd1);
    for (int i = 1; i < 24; i++) begin
      if (i == change_at) joy1 = new_j1;
      shift_pulse(half);
      checkOutput($sformatf("bit%0d", i), 32'(JOY_DATA), exp[i] ? 32'd0 : 32'd1);
      if (i == 22) checkOutput("no_early_done", done_cnt, exp_done);
    end
    exp_done++;
    exp_cnt++;
    checkOutput("frame_done_cnt", done_cnt, exp_done);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    shift_pulse(half);
    checkOutput("idle_after_frame", 32'(JOY_DATA), 32'd1);
    checkOutput("done_once", done_cnt, exp_done);
  endtask

  initial begin
    reset    = 1'b1;
    JOY_LOAD = 1'b0;
    JOY_CLK  = 1'b0;
    exp_cnt  = 8'd0;
    applyStimulus(12'h000, 12'h000);
    cycles(4);
    checkOutput("rst_data",  32'(JOY_DATA),    32'd1);
    checkOutput("rst_cnt",   32'(frame_cnt),   32'd0);
    checkOutput("rst_short", 32'(short_frame), 32'd0);
    checkOutput("rst_done",  done_cnt,         32'd0);
    JOY_LOAD = 1'b1;
    reset    = 1'b0;
    cycles(10);
    checkOutput("idle_data", 32'(JOY_DATA), 32'd1);

    $display("[TB] single frame");
    applyStimulus(12'h005, 12'h800);
    load_pulse(20);
    shift_frame(24'h800005, 20, -1, 12'h000);

    $display("[TB] input change mid-frame");
    load_pulse(20);
    shift_frame(24'h800005, 20, 6, 12'hFFF);
    load_pulse(20);
    shift_frame(24'h800FFF, 20, -1, 12'h000);

    $display("[TB] short frame");
    applyStimulus(12'h005, 12'h800);
    checkOutput("short_clear", 32'(short_frame), 32'd0);
    load_pulse(20);
    repeat (10) shift_pulse(20);
    load_pulse(20);
    checkOutput("short_set",     32'(short_frame), 32'd1);
    checkOutput("short_no_done", done_cnt,         exp_done);
    checkOutput("short_cnt",     32'(frame_cnt),   32'(exp_cnt));
    checkOutput("reload_data",   32'(JOY_DATA),    32'd0);
    shift_frame(24'h800005, 20, -1, 12'h000);

    $display("[TB] glitch rejection");
    load_pulse(20);
    for (int k = 0; k < 2; k++) begin
      JOY_CLK = 1'b1;
      cycles(1);
      JOY_CLK = 1'b0;
      cycles(10);
      checkOutput($sformatf("glitch%0d", k), 32'(JOY_DATA), 32'd0);
    end
    JOY_CLK = 1'b1;
    cycles(3);
    JOY_CLK = 1'b0;
    cycles(10);
    checkOutput("pulse3_a", 32'(JOY_DATA), 32'd1);
    JOY_CLK = 1'b1;
    cycles(3);
    JOY_CLK = 1'b0;
    cycles(10);
    checkOutput("pulse3_b", 32'(JOY_DATA), 32'd0);

    $display("[TB] reset mid-frame");
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    exp_cnt = 8'd0;
    cycles(2);
    checkOutput("midrst_data",  32'(JOY_DATA),    32'd1);
    checkOutput("midrst_cnt",   32'(frame_cnt),   32'd0);
    checkOutput("midrst_short", 32'(short_frame), 32'd0);
    checkOutput("midrst_done",  done_cnt,         exp_done);

    $display("[TB] simultaneous load and clock");
    applyStimulus(12'h003, 12'h800);
    load_pulse(20);
    shift_pulse(20);
    checkOutput("simul_pre", 32'(JOY_DATA), 32'd0);
    JOY_LOAD = 1'b0;
    JOY_CLK  = 1'b1;
    cycles(20);
    checkOutput("simul_short",   32'(short_frame), 32'd1);
    checkOutput("simul_data",    32'(JOY_DATA),    32'd0);
    checkOutput("simul_no_done", done_cnt,         exp_done);
    JOY_CLK = 1'b0;
    cycles(10);
    JOY_LOAD = 1'b1;
    cycles(20);
    shift_frame(24'h800003, 20, -1, 12'h000);

    $display("[TB] frame counter wrap");
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    exp_cnt     = 8'd0;
    done_before = done_cnt;
    for (int f = 0; f < 256; f++) begin
      applyStimulus(12'(f * 37), 12'(f * 11 + 5));
      load_pulse(6);
      shift_frame({joy2, joy1}, 5, -1, 12'h000);
      if (f == 254) checkOutput("cnt_255", 32'(frame_cnt), 32'd255);
    end
    checkOutput("wrap_cnt",  32'(frame_cnt),       32'd0);
    checkOutput("wrap_done", done_cnt - done_before, 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
